hist_dump_receiver: RTL and testbench

Sink for the histogram dump stream: a valid/data/last beat stream that carries NUM_BINS bin counts, bin 0 first. It captures one frame into a bin memory and computes frame statistics (total, peak bin, peak count). It checks the framing and exposes the committed histogram through a registered readback port. It sits on the far side of the histogrammer's uo_out stream, either in the companion FPGA harness or on-chip for self-test.

---
 rtl/hist_pkg.sv | 25 ++
 rtl/hist_bin_mem.sv | 38 +++
 rtl/hist_dump_receiver.sv | 223 ++++++++++++++++++++++
 tb/tb_hist_dump_receiver.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/hist_pkg.sv
// Shared constants, FSM state encoding and error codes for the histogram dump receiver.
package hist_pkg;
  localparam int NUM_BINS  = 64;
  localparam int COUNT_W   = 4;
  localparam int DATA_W    = 8;
  localparam int BIN_IDX_W = $clog2(NUM_BINS);
  localparam int TOTAL_W   = BIN_IDX_W + COUNT_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_COMMIT  = 2'd3
  } rx_state_e;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_SHORT = 2'b01;
  localparam logic [1:0] ERR_LONG  = 2'b10;
  localparam logic [1:0] ERR_UPPER = 2'b11;

  // Nonzero upper data bits outrank any framing error.
  function automatic logic [1:0] err_resolve(input logic upper, input logic [1:0] framing);
    return upper ? ERR_UPPER : framing;
  endfunction
endpackage

// File: rtl/hist_bin_mem.sv
// NUM_BINS x COUNT_W bin memory: one write port, one registered read port, cleared by reset.
module hist_bin_mem
  import hist_pkg::*;
(
  input  logic                 clk,
  input  logic                 bin_reset,
  input  logic                 we,
  input  logic [BIN_IDX_W-1:0] waddr,
  input  logic [COUNT_W-1:0]   wdata,
  input  logic [BIN_IDX_W-1:0] raddr,
  output logic [COUNT_W-1:0]   rdata
);
  logic [COUNT_W-1:0] mem_q [NUM_BINS];
  logic [COUNT_W-1:0] mem_d [NUM_BINS];
  logic [COUNT_W-1:0] rdata_q, rdata_d;

  always_comb begin
    mem_d   = mem_q;
    rdata_d = mem_q[raddr];
    if (we) begin
      mem_d[waddr] = wdata;
    end else begin
      mem_d[waddr] = mem_q[waddr];
    end
  end

  always_ff @(posedge clk or posedge bin_reset) begin
    if (bin_reset) begin
      mem_q   <= '{default: '0};
      rdata_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/hist_dump_receiver.sv
// Histogram dump stream sink: captures a frame, checks framing, commits stats and bin readback.
// HIST_RX_DBLBUF_EN selects a double-buffered bin memory that swaps only on good frames.
module hist_dump_receiver
  import hist_pkg::*;
(
  input  logic                 clk,
  input  logic                 bin_reset,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_last,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic [1:0]           err_code,
  output logic [TOTAL_W-1:0]   total_count,
  output logic [BIN_IDX_W-1:0] peak_bin,
  output logic [COUNT_W-1:0]   peak_count,
  output logic [7:0]           frame_cnt,
  input  logic [BIN_IDX_W-1:0] rd_addr,
  output logic [COUNT_W-1:0]   rd_data
);
  localparam logic [BIN_IDX_W-1:0] LAST_IDX = BIN_IDX_W'(NUM_BINS - 1);

  rx_state_e              state_q, state_d;
  logic [BIN_IDX_W-1:0]   idx_q, idx_d;
  logic [TOTAL_W-1:0]     tot_acc_q, tot_acc_d;
  logic [BIN_IDX_W-1:0]   pk_bin_acc_q, pk_bin_acc_d;
  logic [COUNT_W-1:0]     pk_cnt_acc_q, pk_cnt_acc_d;
  logic                   upper_acc_q, upper_acc_d;
  logic                   frame_done_q, frame_done_d;
  logic                   frame_err_q, frame_err_d;
  logic [1:0]             err_code_q, err_code_d;
  logic [TOTAL_W-1:0]     total_count_q, total_count_d;
  logic [BIN_IDX_W-1:0]   peak_bin_q, peak_bin_d;
  logic [COUNT_W-1:0]     peak_count_q, peak_count_d;
  logic [7:0]             frame_cnt_q, frame_cnt_d;

  logic [COUNT_W-1:0]     beat_cnt_s;
  logic                   beat_upper_s;
  logic                   mem_we_s;
  logic [BIN_IDX_W-1:0]   mem_waddr_s;
  logic                   end_good_s, end_bad_s, commit_good_s;
  logic [1:0]             framing_s;

  assign beat_cnt_s   = in_data[COUNT_W-1:0];
  assign beat_upper_s = |in_data[DATA_W-1:COUNT_W];

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    tot_acc_d     = tot_acc_q;
    pk_bin_acc_d  = pk_bin_acc_q;
    pk_cnt_acc_d  = pk_cnt_acc_q;
    upper_acc_d   = upper_acc_q;
    frame_done_d  = 1'b0;
    frame_err_d   = 1'b0;
    err_code_d    = err_code_q;
    total_count_d = total_count_q;
    peak_bin_d    = peak_bin_q;
    peak_count_d  = peak_count_q;
    frame_cnt_d   = frame_cnt_q;
    mem_we_s      = 1'b0;
    mem_waddr_s   = idx_q;
    end_good_s    = 1'b0;
    end_bad_s     = 1'b0;
    framing_s     = ERR_NONE;

    case (state_q)
      // COMMIT behaves like IDLE so a beat arriving there starts the next frame.
      ST_IDLE, ST_COMMIT: begin
        if (in_valid) begin
          mem_we_s     = 1'b1;
          mem_waddr_s  = '0;
          tot_acc_d    = TOTAL_W'(beat_cnt_s);
          pk_bin_acc_d = '0;
          pk_cnt_acc_d = beat_cnt_s;
          upper_acc_d  = beat_upper_s;
          idx_d        = BIN_IDX_W'(1);
          if (in_last) begin
            end_bad_s = 1'b1;
            framing_s = ERR_SHORT;
            state_d   = ST_COMMIT;
          end else begin
            state_d = ST_CAPTURE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (in_valid) begin
          mem_we_s    = 1'b1;
          tot_acc_d   = tot_acc_q + TOTAL_W'(beat_cnt_s);
          upper_acc_d = upper_acc_q | beat_upper_s;
          idx_d       = idx_q + BIN_IDX_W'(1);
          if (beat_cnt_s > pk_cnt_acc_q) begin
            pk_bin_acc_d = idx_q;
            pk_cnt_acc_d = beat_cnt_s;
          end else begin
            pk_bin_acc_d = pk_bin_acc_q;
          end
          if (in_last) begin
            state_d    = ST_COMMIT;
            end_good_s = (idx_q == LAST_IDX);
            end_bad_s  = (idx_q != LAST_IDX);
            framing_s  = ERR_SHORT;
          end else if (idx_q == LAST_IDX) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_CAPTURE;
          end
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_DRAIN: begin
        if (in_valid) begin
          upper_acc_d = upper_acc_q | beat_upper_s;
          if (in_last) begin
            end_bad_s = 1'b1;
            framing_s = ERR_LONG;
            state_d   = ST_COMMIT;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered on the last beat so they appear during COMMIT.
    commit_good_s = end_good_s & ~upper_acc_d;
    if (commit_good_s) begin
      frame_done_d  = 1'b1;
      total_count_d = tot_acc_d;
      peak_bin_d    = pk_bin_acc_d;
      peak_count_d  = pk_cnt_acc_d;
      frame_cnt_d   = frame_cnt_q + 8'd1;
    end else if (end_good_s | end_bad_s) begin
      frame_err_d = 1'b1;
      err_code_d  = err_resolve(upper_acc_d, framing_s);
    end else begin
      frame_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge bin_reset) begin
    if (bin_reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      tot_acc_q     <= '0;
      pk_bin_acc_q  <= '0;
      pk_cnt_acc_q  <= '0;
      upper_acc_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= ERR_NONE;
      total_count_q <= '0;
      peak_bin_q    <= '0;
      peak_count_q  <= '0;
      frame_cnt_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      tot_acc_q     <= tot_acc_d;
      pk_bin_acc_q  <= pk_bin_acc_d;
      pk_cnt_acc_q  <= pk_cnt_acc_d;
      upper_acc_q   <= upper_acc_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
      err_code_q    <= err_code_d;
      total_count_q <= total_count_d;
      peak_bin_q    <= peak_bin_d;
      peak_count_q  <= peak_count_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

`ifdef HIST_RX_DBLBUF_EN
  // bank_q names the front (readback) bank; capture always writes the other one.
  logic               bank_q, bank_d;
  logic [COUNT_W-1:0] rdata0_s, rdata1_s;

  always_comb begin
    bank_d = bank_q ^ commit_good_s;
  end

  always_ff @(posedge clk or posedge bin_reset) begin
    if (bin_reset) begin
      bank_q <= 1'b0;
    end else begin
      bank_q <= bank_d;
    end
  end

  hist_bin_mem u_mem0 (
    .clk(clk), .bin_reset(bin_reset), .we(mem_we_s & bank_q), .waddr(mem_waddr_s),
    .wdata(beat_cnt_s), .raddr(rd_addr), .rdata(rdata0_s)
  );
  hist_bin_mem u_mem1 (
    .clk(clk), .bin_reset(bin_reset), .we(mem_we_s & ~bank_q), .waddr(mem_waddr_s),
    .wdata(beat_cnt_s), .raddr(rd_addr), .rdata(rdata1_s)
  );

  assign rd_data = bank_q ? rdata1_s : rdata0_s;
`else
  hist_bin_mem u_mem (
    .clk(clk), .bin_reset(bin_reset), .we(mem_we_s), .waddr(mem_waddr_s),
    .wdata(beat_cnt_s), .raddr(rd_addr), .rdata(rd_data)
  );
`endif

  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign total_count = total_count_q;
  assign peak_bin    = peak_bin_q;
  assign peak_count  = peak_count_q;
  assign frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_hist_dump_receiver.sv
// Directed self-checking bench for hist_dump_receiver (default and HIST_RX_DBLBUF_EN builds).
module tb_hist_dump_receiver;
  import hist_pkg::*;

  localparam int M_RAMP  = 0;
  localparam int M_SEVEN = 1;
  localparam int M_ZERO  = 2;

  logic                 clk = 1'b0;
  logic                 bin_reset;
  logic                 in_valid;
  logic [DATA_W-1:0]    in_data;
  logic                 in_last;
  logic                 frame_done;
  logic                 frame_err;
  logic [1:0]           err_code;
  logic [TOTAL_W-1:0]   total_count;
  logic [BIN_IDX_W-1:0] peak_bin;
  logic [COUNT_W-1:0]   peak_count;
  logic [7:0]           frame_cnt;
  logic [BIN_IDX_W-1:0] rd_addr;
  logic [COUNT_W-1:0]   rd_data;

  int tests_run = 0;
  int tests_failed = 0;

  hist_dump_receiver dut (
    .clk(clk), .bin_reset(bin_reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .frame_done(frame_done), .frame_err(frame_err),
    .err_code(err_code), .total_count(total_count), .peak_bin(peak_bin),
    .peak_count(peak_count), .frame_cnt(frame_cnt), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pat(input int mode, input int i);
    case (mode)
      M_RAMP:  pat = DATA_W'(i % 16);
      M_SEVEN: pat = 8'd7;
      default: pat = 8'd0;
    endcase
  endfunction

  // Drives beats first..first+n-1; returns 1 time unit after the edge that took the final beat.
  task automatic send(input int first, input int n, input int mode, input bit last,
                      input int gap_pct, input int bad_at, input logic [DATA_W-1:0] bad_val);
    for (int i = first; i < first + n; i++) begin
      for (int g = 0; g < 8 && $urandom_range(99) < gap_pct; g++) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_last  = last && (i == first + n - 1);
      in_data  = (i == bad_at) ? bad_val : pat(mode, i);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 8'h00;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    bin_reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", frame_done, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_total", total_count, 0);
    chk("rst_pbin", peak_bin, 0);
    chk("rst_pcnt", peak_count, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_rd", rd_data, 0);
    bin_reset = 1'b0;
    tick();

    // Good ramp frame: counts i%16
    send(0, 64, M_RAMP, 1'b1, 0, -1, 8'h00);
    chk("a_done", frame_done, 1);
    chk("a_err", frame_err, 0);
    chk("a_total", total_count, 480);
    chk("a_pcnt", peak_count, 15);
    chk("a_pbin", peak_bin, 15);
    chk("a_fcnt", frame_cnt, 1);
    rd_addr = 6'd37;
    tick();
    chk("a_pulse_off", frame_done, 0);
    chk("a_rd37", rd_data, 5);
    rd_addr = 6'd63;
    tick();
    chk("a_rd63", rd_data, 15);

    // Short frame of 7s, last on beat 10
    send(0, 11, M_SEVEN, 1'b1, 0, -1, 8'h00);
    chk("s_err", frame_err, 1);
    chk("s_done", frame_done, 0);
    chk("s_code", err_code, 1);
    chk("s_total", total_count, 480);
    chk("s_pbin", peak_bin, 15);
    chk("s_fcnt", frame_cnt, 1);
    rd_addr = 6'd5;
    tick();
    chk("s_err_off", frame_err, 0);
`ifdef HIST_RX_DBLBUF_EN
    chk("s_rd5_dbl", rd_data, 5);
`else
    chk("s_rd5_single", rd_data, 7);
`endif

    // Long frame: 70 beats, then a normal frame
    send(0, 70, M_RAMP, 1'b1, 0, -1, 8'h00);
    chk("l_err", frame_err, 1);
    chk("l_code", err_code, 2);
    chk("l_done", frame_done, 0);
    chk("l_fcnt", frame_cnt, 1);
    tick();
    send(0, 64, M_RAMP, 1'b1, 0, -1, 8'h00);
    chk("l2_done", frame_done, 1);
    chk("l2_fcnt", frame_cnt, 2);
    chk("l2_total", total_count, 480);
    chk("l2_code_held", err_code, 2);

    // Upper bits set on beat 5
    send(0, 64, M_RAMP, 1'b1, 0, 5, 8'h23);
    chk("u_err", frame_err, 1);
    chk("u_code", err_code, 3);
    chk("u_done", frame_done, 0);
    chk("u_fcnt", frame_cnt, 2);

    // All 7s with random idle gaps
    send(0, 64, M_SEVEN, 1'b1, 30, -1, 8'h00);
    chk("g_done", frame_done, 1);
    chk("g_total", total_count, 448);
    chk("g_pbin", peak_bin, 0);
    chk("g_pcnt", peak_count, 7);
    chk("g_fcnt", frame_cnt, 3);

    // Back-to-back frames: next beat 0 lands in the COMMIT cycle
    send(0, 64, M_SEVEN, 1'b1, 0, -1, 8'h00);
    chk("b1_done", frame_done, 1);
    chk("b1_fcnt", frame_cnt, 4);
    send(0, 64, M_ZERO, 1'b1, 0, -1, 8'h00);
    chk("b2_done", frame_done, 1);
    chk("b2_fcnt", frame_cnt, 5);
    chk("b2_total", total_count, 0);
    chk("b2_pbin", peak_bin, 0);
    chk("b2_pcnt", peak_count, 0);

    // Async reset at beat 30
    send(0, 30, M_RAMP, 1'b0, 0, -1, 8'h00);
    in_valid = 1'b1;
    in_data  = 8'd14;
    #2;
    bin_reset = 1'b1;
    #1;
    chk("r_fcnt_async", frame_cnt, 0);
    chk("r_total_async", total_count, 0);
    chk("r_code_async", err_code, 0);
    in_valid = 1'b0;
    in_data  = 8'h00;
    tick();
    tick();
    chk("r_done", frame_done, 0);
    chk("r_err", frame_err, 0);
    chk("r_rd", rd_data, 0);
    bin_reset = 1'b0;
    tick();
    send(0, 64, M_RAMP, 1'b1, 0, -1, 8'h00);
    chk("r2_done", frame_done, 1);
    chk("r2_fcnt", frame_cnt, 1);
    chk("r2_total", total_count, 480);

    // Readback while frame 2 (all 7s) is being captured
    rd_addr = 6'd20;
    send(0, 40, M_SEVEN, 1'b0, 0, -1, 8'h00);
`ifdef HIST_RX_DBLBUF_EN
    chk("d_rd_during", rd_data, 4);
`else
    chk("d_rd_during", rd_data, 7);
`endif
    send(40, 24, M_SEVEN, 1'b1, 0, -1, 8'h00);
    chk("d_done", frame_done, 1);
    chk("d_fcnt", frame_cnt, 2);
    tick();
    chk("d_rd_after", rd_data, 7);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
